// File: rtl/jace_bank_mapper_if.sv
// Z80-side bus between the tv80 core and the Jupiter ACE bank mapper.
// The CPU drives address, strobes and write data; the mapper returns readback and wait.
interface jace_bank_mapper_if;
    logic [15:0] cpu_addr;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  data_from_cpu;
    logic [7:0]  data_to_cpu;
    logic        data_to_cpu_oe;
    logic        wait_n;

    modport master (
        output cpu_addr, mreq_n, iorq_n, rd_n, wr_n, data_from_cpu,
        input  data_to_cpu, data_to_cpu_oe, wait_n
    );

    modport slave (
        input  cpu_addr, mreq_n, iorq_n, rd_n, wr_n, data_from_cpu,
        output data_to_cpu, data_to_cpu_oe, wait_n
    );
endinterface

// File: rtl/jace_bank_mapper.sv
// Jupiter ACE memory mapper: region decode, paged 16 KB window at 0x8000-0xBFFF,
// I/O-port bank / write-protect / ROM-write registers and banked-window wait states.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no banked access in progress, wait_n high
// ST_WAIT   | banked access stalled, wait_n low while cnt counts down to 0
// ST_HOLD   | wait served, wait_n high until the CPU drops mreq
module jace_bank_mapper #(
    parameter int         NUM_BANKS   = 4,
    parameter logic [7:0] BANK_PORT   = 8'h7F,
    parameter logic [7:0] ROMWP_PORT  = 8'h7E,
    parameter int         WAIT_STATES = 0,
    localparam int        BANK_BITS   = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    jace_bank_mapper_if.slave      bus,
    output logic                   rom_enable,
    output logic                   sram_enable,
    output logic                   cram_enable,
    output logic                   uram_enable,
    output logic                   xram_enable,
    output logic                   fixed_enable,
    output logic                   bank_enable,
    output logic [BANK_BITS+13:0]  bank_addr,
    output logic                   rom_we,
    output logic                   ram_we
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic       WS_EN    = (WAIT_STATES > 0);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [7:0] NB_LIMIT = 8'(NUM_BANKS);

    logic [BANK_BITS-1:0] bank_reg_q, bank_reg_d;
    logic                 wp_reg_q, wp_reg_d;
    logic                 romwe_reg_q, romwe_reg_d;
    logic                 io_wr, io_wr_q, io_wr_fire;
    logic                 bank_port_hit, romwp_port_hit;
    logic                 mem_cyc;
    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;

    assign mem_cyc      = ~bus.mreq_n;
    assign rom_enable   = mem_cyc & (bus.cpu_addr[15:13] == 3'b000);
    assign sram_enable  = mem_cyc & (bus.cpu_addr[15:11] == 5'b00100);
    assign cram_enable  = mem_cyc & (bus.cpu_addr[15:11] == 5'b00101);
    assign uram_enable  = mem_cyc & (bus.cpu_addr[15:12] == 4'b0011);
    assign xram_enable  = mem_cyc & (bus.cpu_addr[15:14] == 2'b01);
    assign bank_enable  = mem_cyc & (bus.cpu_addr[15:14] == 2'b10);
    assign fixed_enable = mem_cyc & (bus.cpu_addr[15:14] == 2'b11);

    assign bank_addr = {bank_reg_q, bus.cpu_addr[13:0]};
    assign rom_we    = rom_enable & ~bus.wr_n & romwe_reg_q;
    // Write protect only guards the paged window; fixed RAM stays writable.
    assign ram_we    = ~bus.wr_n & (sram_enable | cram_enable | uram_enable |
                                    xram_enable | fixed_enable |
                                    (bank_enable & ~wp_reg_q));

    assign bank_port_hit  = (bus.cpu_addr[7:0] == BANK_PORT);
    assign romwp_port_hit = (bus.cpu_addr[7:0] == ROMWP_PORT);
    assign io_wr          = ~bus.iorq_n & ~bus.wr_n;
    // Edge detect so a long OUT strobe updates the registers exactly once.
    assign io_wr_fire     = io_wr & ~io_wr_q;

    always_comb begin
        bank_reg_d  = bank_reg_q;
        wp_reg_d    = wp_reg_q;
        romwe_reg_d = romwe_reg_q;
        if (io_wr_fire && bank_port_hit) begin
            wp_reg_d = bus.data_from_cpu[7];
            if ({1'b0, bus.data_from_cpu[6:0]} < NB_LIMIT) begin
                bank_reg_d = bus.data_from_cpu[BANK_BITS-1:0];
            end
        end
        if (io_wr_fire && romwp_port_hit) begin
            romwe_reg_d = bus.data_from_cpu[0];
        end
    end

    always_comb begin
        bus.data_to_cpu    = 8'h00;
        bus.data_to_cpu_oe = 1'b0;
        if (~bus.iorq_n && ~bus.rd_n) begin
            if (bank_port_hit) begin
                bus.data_to_cpu    = {wp_reg_q, 7'(bank_reg_q)};
                bus.data_to_cpu_oe = 1'b1;
            end else if (romwp_port_hit) begin
                bus.data_to_cpu    = {7'b0, romwe_reg_q};
                bus.data_to_cpu_oe = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bank_enable && WS_EN) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (bus.mreq_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.wait_n = (state_q != ST_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_reg_q  <= '0;
            wp_reg_q    <= 1'b0;
            romwe_reg_q <= 1'b0;
            io_wr_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
        end else begin
            bank_reg_q  <= bank_reg_d;
            wp_reg_q    <= wp_reg_d;
            romwe_reg_q <= romwe_reg_d;
            io_wr_q     <= io_wr;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_jace_bank_mapper.sv
// Bench for jace_bank_mapper: two instances (4 banks / 3 waits, 8 banks / no waits)
// share one Z80 bus and are compared against a behavioural map model.
module tb_jace_bank_mapper;
    localparam int WAIT0 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr;
    logic        mreq_n, iorq_n, rd_n, wr_n;
    logic [7:0]  dout;

    int   vectors = 0;
    int   miscompares = 0;
    int   bank_m [2];
    logic wp_m, romwe_m;
    int   nb [2] = '{4, 8};

    always #5 clk = ~clk;

    jace_bank_mapper_if if0 ();
    jace_bank_mapper_if if1 ();

    assign if0.cpu_addr = addr;      assign if1.cpu_addr = addr;
    assign if0.mreq_n = mreq_n;      assign if1.mreq_n = mreq_n;
    assign if0.iorq_n = iorq_n;      assign if1.iorq_n = iorq_n;
    assign if0.rd_n = rd_n;          assign if1.rd_n = rd_n;
    assign if0.wr_n = wr_n;          assign if1.wr_n = wr_n;
    assign if0.data_from_cpu = dout; assign if1.data_from_cpu = dout;

    // enables packed as {rom, sram, cram, uram, xram, bank, fixed}
    wire [6:0]  en0, en1;
    wire [15:0] ba0;
    wire [16:0] ba1;
    wire        rwe0, rwe1, mwe0, mwe1;

    jace_bank_mapper #(.NUM_BANKS(4), .WAIT_STATES(WAIT0)) u0 (
        .clk(clk), .reset(reset), .bus(if0),
        .rom_enable(en0[6]), .sram_enable(en0[5]), .cram_enable(en0[4]),
        .uram_enable(en0[3]), .xram_enable(en0[2]), .bank_enable(en0[1]),
        .fixed_enable(en0[0]), .bank_addr(ba0), .rom_we(rwe0), .ram_we(mwe0)
    );

    jace_bank_mapper #(.NUM_BANKS(8), .WAIT_STATES(0)) u1 (
        .clk(clk), .reset(reset), .bus(if1),
        .rom_enable(en1[6]), .sram_enable(en1[5]), .cram_enable(en1[4]),
        .uram_enable(en1[3]), .xram_enable(en1[2]), .bank_enable(en1[1]),
        .fixed_enable(en1[0]), .bank_addr(ba1), .rom_we(rwe1), .ram_we(mwe1)
    );

    function automatic logic [6:0] region(int a);
        if (a < 'h2000) return 7'b1000000;
        if (a < 'h2800) return 7'b0100000;
        if (a < 'h3000) return 7'b0010000;
        if (a < 'h4000) return 7'b0001000;
        if (a < 'h8000) return 7'b0000100;
        if (a < 'hC000) return 7'b0000010;
        return 7'b0000001;
    endfunction

    function automatic logic [7:0] exp_rd(int i, logic [7:0] port);
        if (port == 8'h7F) return {wp_m, 7'(bank_m[i])};
        if (port == 8'h7E) return {7'b0, romwe_m};
        return 8'h00;
    endfunction

    task automatic model_reset();
        bank_m[0] = 0; bank_m[1] = 0; wp_m = 1'b0; romwe_m = 1'b0;
    endtask

    task automatic model_out(logic [7:0] port, logic [7:0] d);
        if (port == 8'h7F) begin
            wp_m = d[7];
            for (int i = 0; i < 2; i++)
                if (int'(d[6:0]) < nb[i]) bank_m[i] = int'(d[6:0]);
        end else if (port == 8'h7E) begin
            romwe_m = d[0];
        end
    endtask

    task automatic idle_bus();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic do_out(logic [7:0] port, logic [7:0] d);
        @(negedge clk);
        addr = {8'($urandom), port}; dout = d;
        mreq_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
        @(negedge clk);
        idle_bus();
        model_out(port, d);
    endtask

    task automatic drive_mem(logic [15:0] a, logic wr);
        @(negedge clk);
        addr = a; iorq_n = 1'b1; mreq_n = 1'b0; wr_n = ~wr; rd_n = wr;
        #2;
    endtask

    task automatic drive_in(logic [7:0] port);
        @(negedge clk);
        addr = {8'($urandom), port}; mreq_n = 1'b1; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        @(negedge clk); #2;
        vectors++; if (en0 !== 7'd0 || en1 !== 7'd0) begin miscompares++; $display("FAIL reset_enables: got %b/%b expected 0000000", en0, en1); end
        vectors++; if (if0.wait_n !== 1'b1 || if1.wait_n !== 1'b1) begin miscompares++; $display("FAIL reset_wait_n: got %b/%b expected 1", if0.wait_n, if1.wait_n); end
        vectors++; if (if0.data_to_cpu_oe !== 1'b0 || if0.data_to_cpu !== 8'h00) begin miscompares++; $display("FAIL reset_readback: got oe=%b d=%h expected oe=0 d=00", if0.data_to_cpu_oe, if0.data_to_cpu); end
        drive_mem(16'h8000, 1'b0);
        vectors++; if (en0 !== 7'b0000010 || en1 !== 7'b0000010) begin miscompares++; $display("FAIL reset_bank_en: got %b/%b expected 0000010", en0, en1); end
        vectors++; if (ba0 !== 16'h0000 || ba1 !== 17'h00000) begin miscompares++; $display("FAIL reset_bank_addr: got %h/%h expected 0", ba0, ba1); end
        vectors++; if (if0.wait_n !== 1'b1) begin miscompares++; $display("FAIL reset_access_wait: got %b expected 1", if0.wait_n); end
        idle_bus();
        drive_in(8'h7F);
        vectors++; if (if0.data_to_cpu !== 8'h00 || if0.data_to_cpu_oe !== 1'b1) begin miscompares++; $display("FAIL reset_in7f: got %h oe=%b expected 00 oe=1", if0.data_to_cpu, if0.data_to_cpu_oe); end
        idle_bus();
    endtask

    task automatic test_bank_select();
        do_out(8'h7F, 8'h03);
        drive_in(8'h7F);
        vectors++; if (if0.data_to_cpu !== 8'h03 || if1.data_to_cpu !== 8'h03) begin miscompares++; $display("FAIL bank_in3: got %h/%h expected 03", if0.data_to_cpu, if1.data_to_cpu); end
        idle_bus();
        drive_mem(16'h8123, 1'b0);
        vectors++; if (ba0 !== {2'b11, 14'h0123} || ba1 !== 17'h0C123) begin miscompares++; $display("FAIL bank_addr3: got %h/%h expected c123/0c123", ba0, ba1); end
        idle_bus();
        do_out(8'h7F, 8'h05);
        drive_in(8'h7F);
        vectors++; if (if0.data_to_cpu !== 8'h03) begin miscompares++; $display("FAIL bank_out_of_range: got %h expected 03", if0.data_to_cpu); end
        vectors++; if (if1.data_to_cpu !== 8'h05) begin miscompares++; $display("FAIL bank_in_range8: got %h expected 05", if1.data_to_cpu); end
        idle_bus();
    endtask

    task automatic test_write_protect();
        do_out(8'h7F, 8'h81);
        drive_mem(16'hA000, 1'b1);
        vectors++; if (mwe0 !== 1'b0 || en0 !== 7'b0000010) begin miscompares++; $display("FAIL wp_blocks: got we=%b en=%b expected we=0 en=0000010", mwe0, en0); end
        idle_bus();
        drive_mem(16'h4000, 1'b1);
        vectors++; if (mwe0 !== 1'b1) begin miscompares++; $display("FAIL wp_xram: got %b expected 1", mwe0); end
        idle_bus();
        do_out(8'h7F, 8'h01);
        drive_mem(16'hA000, 1'b1);
        vectors++; if (mwe0 !== 1'b1) begin miscompares++; $display("FAIL wp_cleared: got %b expected 1", mwe0); end
        idle_bus();
    endtask

    task automatic test_rom_we();
        drive_mem(16'h0100, 1'b1);
        vectors++; if (rwe0 !== 1'b0) begin miscompares++; $display("FAIL rom_we_off: got %b expected 0", rwe0); end
        idle_bus();
        do_out(8'h7E, 8'h01);
        drive_mem(16'h0100, 1'b1);
        vectors++; if (rwe0 !== 1'b1 || mwe0 !== 1'b0) begin miscompares++; $display("FAIL rom_we_on: got rom_we=%b ram_we=%b expected 1/0", rwe0, mwe0); end
        idle_bus();
        drive_in(8'h7E);
        vectors++; if (if0.data_to_cpu !== 8'h01 || if0.data_to_cpu_oe !== 1'b1) begin miscompares++; $display("FAIL romwp_in: got %h oe=%b expected 01 oe=1", if0.data_to_cpu, if0.data_to_cpu_oe); end
        idle_bus();
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        addr = 16'($urandom_range('h8000, 'hBFFF)); mreq_n = 1'b0; rd_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #2;
            vectors++; if (if0.wait_n !== ((k >= 1 && k <= WAIT0) ? 1'b0 : 1'b1)) begin miscompares++; $display("FAIL wait_cycle%0d: got %b", k, if0.wait_n); end
            vectors++; if (if1.wait_n !== 1'b1) begin miscompares++; $display("FAIL nowait_cycle%0d: got %b expected 1", k, if1.wait_n); end
            @(negedge clk);
        end
        idle_bus();
        repeat (2) @(negedge clk);
        addr = 16'h9000; mreq_n = 1'b0; rd_n = 1'b0;
        @(negedge clk); #2;
        vectors++; if (if0.wait_n !== 1'b0) begin miscompares++; $display("FAIL rst_wait_c1: got %b expected 0", if0.wait_n); end
        @(negedge clk); #2;
        vectors++; if (if0.wait_n !== 1'b0) begin miscompares++; $display("FAIL rst_wait_c2: got %b expected 0", if0.wait_n); end
        reset = 1'b1;
        @(negedge clk); #2;
        vectors++; if (if0.wait_n !== 1'b1) begin miscompares++; $display("FAIL rst_wait_c3: got %b expected 1", if0.wait_n); end
        reset = 1'b0;
        idle_bus();
        model_reset();
        drive_in(8'h7F);
        vectors++; if (if0.data_to_cpu !== 8'h00) begin miscompares++; $display("FAIL rst_clears_bank: got %h expected 00", if0.data_to_cpu); end
        idle_bus();
    endtask

    task automatic test_reset_wins();
        do_out(8'h7F, 8'h02);
        @(negedge clk);
        addr = 16'h007F; dout = 8'h01; iorq_n = 1'b0; wr_n = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_bus();
        model_reset();
        drive_in(8'h7F);
        vectors++; if (if0.data_to_cpu !== 8'h00 || if1.data_to_cpu !== 8'h00) begin miscompares++; $display("FAIL reset_wins: got %h/%h expected 00", if0.data_to_cpu, if1.data_to_cpu); end
        idle_bus();
    endtask

    task automatic test_held_strobe();
        @(negedge clk);
        addr = 16'h127F; dout = 8'h01; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (5) @(negedge clk);
        dout = 8'h02;
        repeat (5) @(negedge clk);
        idle_bus();
        model_out(8'h7F, 8'h01);
        drive_in(8'h7F);
        vectors++; if (if0.data_to_cpu !== 8'h01 || if1.data_to_cpu !== 8'h01) begin miscompares++; $display("FAIL held_strobe: got %h/%h expected 01", if0.data_to_cpu, if1.data_to_cpu); end
        idle_bus();
    endtask

    task automatic test_random();
        logic [7:0]  d, port;
        logic [15:0] a;
        logic        wr, exp_mwe, exp_rwe, exp_oe;
        logic [6:0]  rg;
        int          op;
        for (int n = 0; n < 120; n++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    d = {1'($urandom), 7'($urandom_range(0, 11))};
                    do_out(8'h7F, d);
                end
                1: do_out(8'h7E, 8'($urandom));
                2: begin
                    case ($urandom_range(0, 2))
                        0: port = 8'h7F;
                        1: port = 8'h7E;
                        default: port = 8'($urandom_range(0, 'h7D));
                    endcase
                    drive_in(port);
                    exp_oe = (port == 8'h7F) || (port == 8'h7E);
                    vectors++; if (if0.data_to_cpu !== exp_rd(0, port) || if0.data_to_cpu_oe !== exp_oe) begin miscompares++; $display("FAIL rnd_in0 port %h: got %h oe=%b expected %h oe=%b", port, if0.data_to_cpu, if0.data_to_cpu_oe, exp_rd(0, port), exp_oe); end
                    vectors++; if (if1.data_to_cpu !== exp_rd(1, port) || if1.data_to_cpu_oe !== exp_oe) begin miscompares++; $display("FAIL rnd_in1 port %h: got %h oe=%b expected %h oe=%b", port, if1.data_to_cpu, if1.data_to_cpu_oe, exp_rd(1, port), exp_oe); end
                    idle_bus();
                end
                default: begin
                    a  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range('h8000, 'hBFFF)) : 16'($urandom);
                    wr = 1'($urandom);
                    drive_mem(a, wr);
                    rg = region(int'(a));
                    exp_mwe = wr && (((rg & 7'b0111101) != 7'd0) || (rg[1] && !wp_m));
                    exp_rwe = wr && rg[6] && romwe_m;
                    vectors++; if (en0 !== rg || en1 !== rg) begin miscompares++; $display("FAIL rnd_en @%h: got %b/%b expected %b", a, en0, en1, rg); end
                    vectors++; if (ba0 !== 16'(bank_m[0] * 16384 + int'(a[13:0])) || ba1 !== 17'(bank_m[1] * 16384 + int'(a[13:0]))) begin miscompares++; $display("FAIL rnd_bank_addr @%h: got %h/%h expected bank %0d/%0d", a, ba0, ba1, bank_m[0], bank_m[1]); end
                    vectors++; if (mwe0 !== exp_mwe || mwe1 !== exp_mwe) begin miscompares++; $display("FAIL rnd_ram_we @%h: got %b/%b expected %b", a, mwe0, mwe1, exp_mwe); end
                    vectors++; if (rwe0 !== exp_rwe || rwe1 !== exp_rwe) begin miscompares++; $display("FAIL rnd_rom_we @%h: got %b/%b expected %b", a, rwe0, rwe1, exp_rwe); end
                    idle_bus();
                end
            endcase
        end
    endtask

    initial begin
        addr = 16'h0000; dout = 8'h00;
        idle_bus();
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_bank_select();
        test_write_protect();
        test_rom_we();
        test_wait_states();
        test_reset_wins();
        test_held_strobe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/jace_bank_mapper.md
# jace_bank_mapper

Parametrised memory mapper and bank controller for the Jupiter ACE core. It replaces the fixed region decode with a configurable map. A 16 KB window at 0x8000–0xBFFF is paged among `NUM_BANKS` external banks, and ROM write enable and window write protect are controlled through I/O ports. Slow banked memory gets wait states inserted. It sits between the tv80 CPU bus and the on-chip RAM/ROM blocks in the `clk_65` domain, and drives their enables and the CPU read-data override.

## Interface
- `NUM_BANKS`, 4: banks selectable in window 0x8000–0xBFFF; legal range 2–128.
- `BANK_PORT`, 8'h7F: I/O low-address byte of the bank/protect register.
- `ROMWP_PORT`, 8'h7E: I/O low-address byte of the ROM write-enable register.
- `WAIT_STATES`, 0: `clk` cycles of `wait_n` low per banked-window access; legal range 0–15.
- Derived `BANK_BITS` = max(1, clog2(`NUM_BANKS`)).

Ports:
- `clk` in 1: system clock (`clk_65`).
- `reset` in 1: synchronous, active-high.
- `cpu_addr` in 16: Z80 address.
- `mreq_n`, `iorq_n`, `rd_n`, `wr_n` in 1 each: Z80 strobes.
- `data_from_cpu` in 8: Z80 write data.
- `data_to_cpu` out 8: register readback data.
- `data_to_cpu_oe` out 1: readback valid.
- `wait_n` out 1: Z80 wait.
- `rom_enable`, `sram_enable`, `cram_enable`, `uram_enable`, `xram_enable`, `fixed_enable`, `bank_enable` out 1 each: region selects.
- `bank_addr` out `BANK_BITS`+14: `{bank_reg, cpu_addr[13:0]}`.
- `rom_we` out 1: ROM write strobe.
- `ram_we` out 1: RAM write strobe.

## Operation
- Decode is combinational and gated by `mreq_n`=0:
  - 0000–1FFF → `rom_enable`
  - 2000–27FF → `sram_enable` (1 KB mirrored)
  - 2800–2FFF → `cram_enable`
  - 3000–3FFF → `uram_enable`
  - 4000–7FFF → `xram_enable`
  - 8000–BFFF → `bank_enable`
  - C000–FFFF → `fixed_enable`
- Exactly one enable is high during a memory cycle; all are 0 when `mreq_n`=1.
- `rom_we` = `rom_enable` & ~`wr_n` & `romwe_reg`.
- `ram_we` = ~`wr_n` & any RAM enable; for the banked window it is also gated by ~`wp_reg`.
- I/O write detect: `io_wr` = ~`iorq_n` & ~`wr_n`, registered once into `io_wr_q`. The write fires on the single cycle where `io_wr`=1 and `io_wr_q`=0, so there is exactly one update per Z80 OUT.
- Port match uses `cpu_addr[7:0]` only.
- `BANK_PORT` write:
  - bit 7 → `wp_reg`.
  - bits [`BANK_BITS`-1:0] → `bank_reg`, only if `data_from_cpu[6:0]` < `NUM_BANKS`. Otherwise `bank_reg` is unchanged; `wp_reg` still updates.
- `ROMWP_PORT` write: bit 0 → `romwe_reg`.
- Readback is combinational while ~`iorq_n` & ~`rd_n` & port match:
  - `BANK_PORT` returns `{wp_reg, zero-extended bank_reg}`.
  - `ROMWP_PORT` returns `{7'b0, romwe_reg}`.
  - `data_to_cpu_oe`=1; otherwise `data_to_cpu_oe`=0 and `data_to_cpu`=8'h00.
- Wait FSM states:
  - IDLE: on the first cycle with `bank_enable`=1 and `WAIT_STATES`>0, load `cnt`=`WAIT_STATES`-1 and go to WAIT.
  - WAIT: `wait_n`=0 and `cnt` decrements; at `cnt`=0 go to HOLD.
  - HOLD: `wait_n`=1; return to IDLE when `mreq_n`=1.
- `WAIT_STATES`=0: FSM stays in IDLE and `wait_n` is constantly 1.

## Timing
- Reset values:
  - `bank_reg`=0, `wp_reg`=0, `romwe_reg`=0, `io_wr_q`=0.
  - FSM=IDLE, `wait_n`=1.
  - `data_to_cpu_oe`=0, `data_to_cpu`=0.
- Decode outputs, `rom_we`, `ram_we` and readback are zero-latency combinational.
- A register write is visible on outputs the cycle after the detect cycle; a memory access in that same cycle sees the old bank.
- `wait_n` falls 1 cycle after `bank_enable` rises and stays low exactly `WAIT_STATES` cycles.
- Reset wins over a simultaneous I/O write.
- Reset mid-WAIT forces `wait_n`=1 on the next edge.
- A held `wr_n`/`iorq_n` low across many cycles produces only one register update.
- A bank write during HOLD does not restart the FSM.

## Test plan
- Reset, then MREQ read at 8000: `bank_enable`=1, `bank_addr`=16'h0000, `wait_n`=1, all other enables 0.
- OUT 7F,8'h03 with `NUM_BANKS`=4 → IN 7F returns 8'h03; access to 8123 gives `bank_addr`={2'b11,14'h0123}. Then OUT 7F,8'h05 → `bank_reg` stays 3.
- OUT 7F,8'h81 → write to A000 gives `ram_we`=0 and `bank_enable`=1. OUT 7F,8'h01 → `ram_we`=1.
- Write to 0100 with `romwe_reg`=0 → `rom_we`=0. OUT 7E,8'h01, same write → `rom_we`=1.
- `WAIT_STATES`=3, access 9000 → `wait_n` low exactly cycles 1–3 after `mreq_n` falls. Assert `reset` at cycle 2 → `wait_n`=1 at cycle 3.
- Hold OUT 7F strobe low for 10 cycles with data changing from 8'h01 to 8'h02 mid-strobe → `bank_reg`=1.
